// File: rtl/jump_trajectory_if.sv
// jump_trajectory_if: launch request from the game FSM and the
// flight telemetry that the trajectory block streams back.
interface jump_trajectory_if;
    logic        i_jump_en;
    logic [10:0] i_jump_v_init;
    logic        o_jump_done;
    logic [10:0] o_jump_dist;
    logic [8:0]  o_jump_height;
    logic        o_jump_busy;

    modport master (
        output i_jump_en,
        output i_jump_v_init,
        input  o_jump_done,
        input  o_jump_dist,
        input  o_jump_height,
        input  o_jump_busy
    );

    modport slave (
        input  i_jump_en,
        input  i_jump_v_init,
        output o_jump_done,
        output o_jump_dist,
        output o_jump_height,
        output o_jump_busy
    );
endinterface

// File: rtl/jump_trajectory.sv
// jump_trajectory: ballistic jump integrator; vertical speed drops by one
// unit per physics tick while distance grows by the latched launch speed.
module jump_trajectory #(
    parameter int TICK_DIV = 98304,
    parameter int TICK_W   = 17
) (
    input  logic                clk_jump,
    input  logic                rst_jump,
    jump_trajectory_if.slave    jif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         v_q, v_d;
    logic signed [8:0]  vy_q, vy_d;
    logic signed [14:0] h_acc_q, h_acc_d;
    logic [14:0]        d_acc_q, d_acc_d;
    logic [TICK_W-1:0]  cnt_q, cnt_d;
    logic [10:0]        dist_q, dist_d;
    logic [8:0]         height_q, height_d;
    logic               done_q, done_d;

    logic               tick;
    logic [6:0]         v_sat;
    logic signed [14:0] h_next;
    logic [14:0]        d_next;

    always_ff @(posedge clk_jump) begin
        if (rst_jump) begin
            state_q  <= IDLE;
            v_q      <= '0;
            vy_q     <= '0;
            h_acc_q  <= '0;
            d_acc_q  <= '0;
            cnt_q    <= '0;
            dist_q   <= '0;
            height_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            vy_q     <= vy_d;
            h_acc_q  <= h_acc_d;
            d_acc_q  <= d_acc_d;
            cnt_q    <= cnt_d;
            dist_q   <= dist_d;
            height_q <= height_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        vy_d     = vy_q;
        h_acc_d  = h_acc_q;
        d_acc_d  = d_acc_q;
        cnt_d    = cnt_q;
        dist_d   = dist_q;
        height_d = height_q;
        done_d   = done_q;

        tick   = (cnt_q == TICK_W'(TICK_DIV - 1));
        v_sat  = (jif.i_jump_v_init > 11'd127) ? 7'd127
                                               : jif.i_jump_v_init[6:0];
        h_next = h_acc_q + {{6{vy_q[8]}}, vy_q};
        d_next = d_acc_q + {8'd0, v_q};

        unique case (state_q)
            IDLE: begin
                if (jif.i_jump_en) begin
                    v_d      = v_sat;
                    vy_d     = {2'b00, v_sat};
                    h_acc_d  = '0;
                    d_acc_d  = '0;
                    cnt_d    = '0;
                    dist_d   = '0;
                    height_d = '0;
                    done_d   = 1'b0;
                    state_d  = FLY;
                end
            end
            FLY: begin
                // Abort outranks a landing tick on the same edge.
                if (!jif.i_jump_en) begin
                    state_d = IDLE;
                end else if (tick) begin
                    cnt_d   = '0;
                    vy_d    = vy_q - 9'sd1;
                    d_acc_d = d_next;
                    dist_d  = {3'b000, d_next[14:7]};
                    if (h_next <= 15'sd0 && vy_q <= 9'sd0) begin
                        h_acc_d  = '0;
                        height_d = '0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        h_acc_d  = h_next;
                        height_d = h_next[13:5];
                    end
                end else begin
                    cnt_d = cnt_q + {{(TICK_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (!jif.i_jump_en) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign jif.o_jump_done   = done_q;
    assign jif.o_jump_dist   = dist_q;
    assign jif.o_jump_height = height_q;
    assign jif.o_jump_busy   = (state_q == FLY);
endmodule

// File: tb/tb_jump_trajectory.sv
// tb_jump_trajectory: directed jumps checked against the closed-form
// flight equations, plus abort, reset and handshake scenarios.
module tb_jump_trajectory;
    logic clk_jump;
    logic rst_jump;
    int   errors;
    int   checks;

    jump_trajectory_if jif ();

    jump_trajectory #(
        .TICK_DIV (4),
        .TICK_W   (3)
    ) dut (
        .clk_jump (clk_jump),
        .rst_jump (rst_jump),
        .jif      (jif)
    );

    initial clk_jump = 1'b0;
    always #5 clk_jump = ~clk_jump;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_jump);
        #1;
    endtask

    // mode 0: full flight and handshake, 1: abort at stop_k, 2: reset at stop_k
    task automatic jump(input int vin, input int v, input int stop_k,
                        input int mode);
        int l;
        int h;
        int pk;
        int hk;
        int dk;
        l  = (v == 0) ? 1 : 2 * v + 1;
        pk = 0;
        hk = 0;
        dk = 0;
        jif.i_jump_en     = 1'b1;
        jif.i_jump_v_init = 11'(vin);
        step();
        check("launch_busy", int'(jif.o_jump_busy), 1);
        check("launch_dist", int'(jif.o_jump_dist), 0);
        check("launch_height", int'(jif.o_jump_height), 0);
        check("launch_done", int'(jif.o_jump_done), 0);
        jif.i_jump_v_init = 11'd3;
        for (int k = 1; k <= l; k++) begin
            repeat (3) step();
            if (k == l) check("pre_land_done", int'(jif.o_jump_done), 0);
            step();
            h  = (k == l) ? 0 : (k * v - (k * (k - 1)) / 2) >> 5;
            dk = (k * v) >> 7;
            hk = h;
            check("tick_height", int'(jif.o_jump_height), h);
            check("tick_dist", int'(jif.o_jump_dist), dk);
            check("tick_done", int'(jif.o_jump_done), (k == l) ? 1 : 0);
            if (int'(jif.o_jump_height) > pk) pk = int'(jif.o_jump_height);
            if (mode != 0 && k == stop_k) break;
        end
        if (mode == 0) begin
            check("peak_height", pk, (v * (v + 1) / 2) >> 5);
            check("final_dist", int'(jif.o_jump_dist), (v * (2 * v + 1)) >> 7);
            check("land_busy", int'(jif.o_jump_busy), 0);
            repeat (3) begin
                step();
                check("hold_done", int'(jif.o_jump_done), 1);
                check("hold_dist", int'(jif.o_jump_dist), dk);
            end
            jif.i_jump_en = 1'b0;
            step();
            check("release_done", int'(jif.o_jump_done), 0);
            check("release_busy", int'(jif.o_jump_busy), 0);
            check("release_dist", int'(jif.o_jump_dist), dk);
            step();
            check("idle_done", int'(jif.o_jump_done), 0);
        end else if (mode == 1) begin
            jif.i_jump_en = 1'b0;
            step();
            check("abort_busy", int'(jif.o_jump_busy), 0);
            check("abort_done", int'(jif.o_jump_done), 0);
            repeat (12) step();
            check("abort_done_late", int'(jif.o_jump_done), 0);
            check("abort_height", int'(jif.o_jump_height), hk);
            check("abort_dist", int'(jif.o_jump_dist), dk);
        end else begin
            rst_jump = 1'b1;
            step();
            check("rst_busy", int'(jif.o_jump_busy), 0);
            check("rst_done", int'(jif.o_jump_done), 0);
            check("rst_height", int'(jif.o_jump_height), 0);
            check("rst_dist", int'(jif.o_jump_dist), 0);
            rst_jump      = 1'b0;
            jif.i_jump_en = 1'b0;
            step();
        end
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        rst_jump          = 1'b1;
        jif.i_jump_en     = 1'b0;
        jif.i_jump_v_init = 11'd0;
        repeat (2) step();
        check("reset_done", int'(jif.o_jump_done), 0);
        check("reset_dist", int'(jif.o_jump_dist), 0);
        check("reset_height", int'(jif.o_jump_height), 0);
        check("reset_busy", int'(jif.o_jump_busy), 0);
        rst_jump = 1'b0;
        step();

        jump(127, 127, 0, 0);
        jump(64, 64, 0, 0);
        jump(0, 0, 0, 0);
        jump(900, 127, 0, 0);
        jump(127, 127, 50, 1);
        jump(127, 127, 50, 2);
        jump(5, 5, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jump_trajectory.md
# jump_trajectory

Ballistic jump generator for the jump game. It sits directly downstream of the game FSM. On the FSM's jump enable it latches the launch speed, integrates a parabolic flight on a slow physics tick, and streams horizontal distance and height back to the FSM. It raises done on landing. Its outputs drive the FSM's `i_jump_dist`, `i_jump_height` and `i_jump_done` inputs.

## Interface
- `TICK_DIV`, default 98304: clock cycles per physics tick; must be ≥2. At 25.175 MHz a full-power jump lasts about 1 s. Benches use 4.
- `TICK_W`, default 17: width of the tick counter; must hold TICK_DIV-1.
- `clk_jump` input 1: system clock (25.175 MHz). Single clock domain.
- `rst_jump` input 1: reset, synchronous, active-high.
- `i_jump_en` input 1: level from the FSM. A rising level in IDLE launches a jump. The level must stay high for the whole flight.
- `i_jump_v_init` input 11: launch speed. The value is saturated to 0..127.
- `o_jump_done` output 1: high from the landing edge until `i_jump_en` falls.
- `o_jump_dist` output 11: horizontal distance travelled, in px. Range 0..253.
- `o_jump_height` output 9: current height above the launch block, in px. Range 0..254.
- `o_jump_busy` output 1: high while in FLY.

## Operation
- States are IDLE, FLY and DONE. Reset enters IDLE.
- Reset values: all outputs 0, all accumulators 0, tick counter 0.
- Internal registers:
  - v: 7 bits, latched speed.
  - vy: 9-bit signed vertical speed, in 1/32 px per tick.
  - h_acc: 15-bit signed height, in 1/32 px.
  - d_acc: 15-bit unsigned distance, in 1/128 px.
  - tick counter: TICK_W bits.
- Launch speed saturation: v = 127 if `i_jump_v_init` > 127, else `i_jump_v_init[6:0]`.
- IDLE with `i_jump_en`=1 (launch):
  - Latch v and set vy = v.
  - Clear h_acc, d_acc and the tick counter.
  - Drive `o_jump_dist` and `o_jump_height` to 0 and `o_jump_done` to 0.
  - Go to FLY.
- FLY, cycles without a tick: increment the tick counter.
- FLY, on a tick (counter == TICK_DIV-1):
  - Clear the counter.
  - Compute h_next = h_acc + vy.
  - Update vy to vy - 1 and d_acc to d_acc + v.
  - `o_jump_dist` = (d_acc + v) >> 7.
  - If h_next ≤ 0 and vy ≤ 0, the jump has landed: h_acc = 0, `o_jump_height` = 0, `o_jump_done` = 1, go to DONE.
  - Otherwise h_acc = h_next and `o_jump_height` = h_next >> 5.
- FLY with `i_jump_en`=0 (abort): go to IDLE. Distance and height are held and done stays 0.
- DONE: hold all outputs. When `i_jump_en`=0, drop done and go to IDLE. Distance is held until the next launch.
- Closed-form results:
  - Flight length is 2v+1 ticks for v ≥ 1, and 1 tick for v = 0.
  - Final distance = v(2v+1) >> 7.
  - Peak height = (v(v+1)/2) >> 5.
- Widths: v(v+1)/2 ≤ 8128 and v(2v+1) ≤ 32385, so neither accumulator overflows. vy bottoms out at -128 on the landing tick.

## Timing
- Launch: `i_jump_en` high at edge E0 in IDLE moves the block to FLY at E0, with accumulators cleared on that edge.
- Tick k (k ≥ 1) fires at edge E0 + k·TICK_DIV. Outputs update on that same edge, so they are registered and show no combinational path from the inputs.
- Landing: done rises at E0 + TICK_DIV·(2v+1) and height reads 0 on that same edge.
- Release: `i_jump_en` falling at edge F in DONE clears done at F and returns to IDLE at F. A relaunch is accepted from F+1 onward.
- FSM handshake: the FSM clears enable one cycle after it sees done. Done must therefore stay high for at least that cycle, which it does because it is level-held.
- Reset asserted in any state clears everything on the next edge, even mid-flight. Reset takes priority over every other event, including a tick that fires on the same edge.
- Enable dropping on the same edge as the landing tick: the abort wins. The block goes to IDLE and done stays 0.
- In FLY and DONE, `i_jump_v_init` is ignored; v is sampled only at launch.

## Test plan
- **Full jump:** TICK_DIV=4, v_init=127, en held high. Done rises 1020 cycles after launch. Height peaks at 254 on ticks 127 and 128. Final dist = 253.
- **Mid-power jump:** TICK_DIV=4, v_init=64. Done after 129 ticks (516 cycles). Peak height = 65. Final dist = 64.
- **Zero speed:** v_init=0. Done after 1 tick. Dist = 0 and height = 0 throughout.
- **Saturation:** v_init=11'd900 produces exactly the same trajectory as v_init=127.
- **Mid-flight disturbances:**
  - Drop en at tick 50 of a v=127 jump: the block goes to IDLE, done never rises, dist and height stay at their tick-50 values.
  - Assert rst_jump at tick 50: every output reads 0 on the next edge.
- **Handshake:**
  - Done stays high until en falls.
  - A new en rising two cycles later launches from dist = 0.
  - v_init changes during FLY have no effect on the trajectory.
